// File: rtl/store_unit_if.sv
// Bus bundle between the execute stage, the store unit and the data RAM.
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; the requester must not rely on any field after
// that edge, and the unit ignores req_valid while req_ready is low.
interface store_unit_if #(
  parameter int ADDR_W = 14
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        funct3;
  logic [31:0]       addr;
  logic [31:0]       store_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              done;
  logic              err;

  // Environment side: execute stage plus RAM read data
  modport master (
    output req_valid, funct3, addr, store_data, mem_rdata,
    input  req_ready, mem_addr, mem_re, mem_we, mem_wdata, done, err
  );

  // Store unit side
  modport slave (
    input  req_valid, funct3, addr, store_data, mem_rdata,
    output req_ready, mem_addr, mem_re, mem_we, mem_wdata, done, err
  );
endinterface

// File: rtl/store_unit.sv
// sb/sh/sw store engine for word-organised data RAM. Full words are written
// directly; bytes and halfwords go through read-modify-write.
module store_unit #(
  parameter int ADDR_W = 14,
  parameter int RD_LAT = 1
) (
  input  logic           clk,
  input  logic           reset,
  store_unit_if.slave    bus,
  output logic [1:0]     dbg_state_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] WR   = 2'd3;

  // WAIT lasts RD_LAT cycles; counter reaches zero on the last one
  localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

  logic [1:0]        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [1:0]        lane_q, lane_d;
  logic              sh_q, sh_d;
  logic [15:0]       data_q, data_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              accept;
  logic              legal;
  logic [31:0]       merged;
  logic              unused_addr_hi;

  // Address bits above the RAM size are ignored so addresses wrap
  assign unused_addr_hi = ^bus.addr[31:ADDR_W+2];

  assign accept = bus.req_valid && (state_q == IDLE);

  // Width and alignment check, evaluated on the request as presented
  always_comb begin
    legal = 1'b0;
    case (bus.funct3)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~bus.addr[0];
      3'b010:  legal = (bus.addr[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  // Little-endian lane merge of the latched store data into the read word
  always_comb begin
    merged = bus.mem_rdata;
    if (sh_q) begin
      if (lane_q[1]) merged[31:16] = data_q;
      else           merged[15:0]  = data_q;
    end else begin
      case (lane_q)
        2'd0:    merged[7:0]   = data_q[7:0];
        2'd1:    merged[15:8]  = data_q[7:0];
        2'd2:    merged[23:16] = data_q[7:0];
        default: merged[31:24] = data_q[7:0];
      endcase
    end
  end

  // Next-state logic for the IDLE/RD/WAIT/WR sequence and result pulses
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    maddr_d = maddr_q;
    lane_d  = lane_q;
    sh_d    = sh_q;
    data_d  = data_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!legal) begin
            err_d = 1'b1;
          end else begin
            maddr_d = bus.addr[ADDR_W+1:2];
            lane_d  = bus.addr[1:0];
            sh_d    = (bus.funct3 == 3'b001);
            data_d  = bus.store_data[15:0];
            if (bus.funct3 == 3'b010) begin
              wdata_d = bus.store_data;
              state_d = WR;
            end else begin
              state_d = RD;
            end
          end
        end
      end
      RD: begin
        cnt_d   = WAIT_INIT;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          wdata_d = merged;
          state_d = WR;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    endcase
  end

  // State and datapath registers; reset abandons any store in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      maddr_q <= '0;
      lane_q  <= 2'd0;
      sh_q    <= 1'b0;
      data_q  <= 16'd0;
      wdata_q <= 32'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      maddr_q <= maddr_d;
      lane_q  <= lane_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.mem_re    = (state_q == RD);
  assign bus.mem_we    = (state_q == WR);
  assign bus.mem_addr  = maddr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_store_unit.sv
// Bench for store_unit: one instance with RD_LAT=1, one with RD_LAT=3,
// each backed by a behavioural RAM with matching read latency.
module tb_store_unit;

  localparam int AW = 14;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  store_unit_if #(.ADDR_W(AW)) if1 ();
  store_unit_if #(.ADDR_W(AW)) if2 ();
  logic [1:0] st1, st2;

  store_unit #(.ADDR_W(AW), .RD_LAT(1)) dut1 (
    .clk(clk), .reset(rst_n), .bus(if1), .dbg_state_o(st1)
  );
  store_unit #(.ADDR_W(AW), .RD_LAT(3)) dut2 (
    .clk(clk), .reset(rst_n), .bus(if2), .dbg_state_o(st2)
  );

  // ---------------- RAM models ----------------
  logic [31:0]   ram1 [0:(1<<AW)-1];
  logic [31:0]   ram2 [0:(1<<AW)-1];
  logic [31:0]   rd1_q, p2a, p2b, p2c;
  logic          poke_en = 1'b0;
  logic [AW-1:0] poke_addr = '0;
  logic [31:0]   poke_data = 32'd0;

  always @(posedge clk) begin
    if (poke_en) ram1[poke_addr] <= poke_data;
    if (if1.mem_we) ram1[if1.mem_addr] <= if1.mem_wdata;
    if (if1.mem_re) rd1_q <= ram1[if1.mem_addr];
  end
  assign if1.mem_rdata = rd1_q;

  always @(posedge clk) begin
    if (poke_en) ram2[poke_addr] <= poke_data;
    if (if2.mem_we) ram2[if2.mem_addr] <= if2.mem_wdata;
    if (if2.mem_re) p2a <= ram2[if2.mem_addr];
    p2b <= p2a;
    p2c <= p2b;
  end
  assign if2.mem_rdata = p2c;

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;
  logic [45:0] exp1_q[$];
  logic [45:0] exp2_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit model_legal(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'b000:  return 1'b1;
      3'b001:  return a[0] == 1'b0;
      3'b010:  return a[1:0] == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_merge(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] old, input logic [31:0] d);
    logic [31:0] mask;
    int sh;
    case (f3)
      3'b000:  begin sh = 8 * int'(a[1:0]); mask = 32'h0000_00FF << sh; end
      3'b001:  begin sh = 16 * int'(a[1]);  mask = 32'h0000_FFFF << sh; end
      default: begin sh = 0;                mask = 32'hFFFF_FFFF;       end
    endcase
    return (old & ~mask) | ((d << sh) & mask);
  endfunction

  // Scoreboard: every RAM write is compared against the oldest expected one
  always @(negedge clk) begin
    if (rst_n && if1.mem_we) begin
      if (exp1_q.size() == 0) check("wr1_unexpected", 64'd1, 64'd0);
      else check("wr1_word", {18'd0, if1.mem_addr, if1.mem_wdata}, {18'd0, exp1_q.pop_front()});
    end
    if (rst_n && if2.mem_we) begin
      if (exp2_q.size() == 0) check("wr2_unexpected", 64'd1, 64'd0);
      else check("wr2_word", {18'd0, if2.mem_addr, if2.mem_wdata}, {18'd0, exp2_q.pop_front()});
    end
    if (if1.done && if1.err) check("done_err_excl1", 64'd1, 64'd0);
    if (if2.done && if2.err) check("done_err_excl2", 64'd1, 64'd0);
  end

  // ---------------- driver tasks ----------------
  task automatic poke(input logic [AW-1:0] wa, input logic [31:0] wd);
    poke_en = 1'b1; poke_addr = wa; poke_data = wd;
    @(posedge clk); #1;
    poke_en = 1'b0;
    @(negedge clk);
  endtask

  // Issue one store on the RD_LAT=1 unit (called at a negedge) and follow it
  // until done/err; returns at the negedge of the done/err cycle.
  task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    bit legal;
    int exp_lat, exp_re, re_cnt, we_at, got_lat;
    legal   = model_legal(f3, a);
    exp_lat = !legal ? 1 : ((f3 == 3'b010) ? 2 : 4);
    exp_re  = (legal && f3 != 3'b010) ? 1 : 0;
    check("ready_at_issue", {63'd0, if1.req_ready}, 64'd1);
    if1.req_valid = 1'b1; if1.funct3 = f3; if1.addr = a; if1.store_data = d;
    if (legal) exp1_q.push_back({a[AW+1:2], model_merge(f3, a, ram1[a[AW+1:2]], d)});
    @(posedge clk); #1;
    if1.req_valid = 1'b0;
    if1.addr = $urandom; if1.store_data = $urandom; if1.funct3 = 3'($urandom_range(0, 7));
    re_cnt = 0; we_at = 0; got_lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (if1.mem_re) re_cnt++;
      if (if1.mem_we) we_at = n;
      if (if1.done || if1.err) begin got_lat = n; break; end
    end
    check("latency", 64'(got_lat), 64'(exp_lat));
    check("re_count", 64'(re_cnt), 64'(exp_re));
    check("we_cycle", 64'(we_at), legal ? 64'(exp_lat - 1) : 64'd0);
    check("err_flag", {63'd0, if1.err}, {63'd0, !legal});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int got_lat, re_at, we_at;
    logic [2:0] f3;
    if1.req_valid = 1'b0; if1.funct3 = 3'd0; if1.addr = 32'd0; if1.store_data = 32'd0;
    if2.req_valid = 1'b0; if2.funct3 = 3'd0; if2.addr = 32'd0; if2.store_data = 32'd0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", {63'd0, if1.req_ready}, 64'd1);
    check("rst_re_we", {62'd0, if1.mem_re, if1.mem_we}, 64'd0);
    check("rst_done_err", {62'd0, if1.done, if1.err}, 64'd0);
    check("rst_addr", {50'd0, if1.mem_addr}, 64'd0);
    check("rst_wdata", {32'd0, if1.mem_wdata}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // sb merge and sh both lanes
    poke(14'd5, 32'h1122_3344);
    do_store(3'b000, 32'h16, 32'h0000_00AB);
    check("ram_after_sb", {32'd0, ram1[5]}, {32'd0, 32'h11AB_3344});
    poke(14'd5, 32'h1122_3344);
    do_store(3'b001, 32'h16, 32'h1234_BEEF);
    poke(14'd5, 32'h1122_3344);
    do_store(3'b001, 32'h14, 32'h1234_BEEF);
    check("ram_after_sh_lo", {32'd0, ram1[5]}, {32'd0, 32'h1122_BEEF});

    // sw direct, then sb issued in the done cycle
    do_store(3'b010, 32'h14, 32'hDEAD_BEEF);
    do_store(3'b000, 32'h17, 32'h0000_005A);
    check("ram_after_b2b", {32'd0, ram1[5]}, {32'd0, 32'h5AAD_BEEF});

    // Misaligned and illegal requests: one-cycle err, no access
    do_store(3'b010, 32'h15, 32'h0);
    @(negedge clk);
    check("err_one_cycle_sw", {62'd0, if1.err, if1.req_ready}, 64'd1);
    do_store(3'b001, 32'h13, 32'h0);
    @(negedge clk);
    check("err_one_cycle_sh", {62'd0, if1.err, if1.req_ready}, 64'd1);
    do_store(3'b011, 32'h14, 32'h0);
    @(negedge clk);
    check("err_one_cycle_f3", {62'd0, if1.err, if1.req_ready}, 64'd1);

    // Random back-to-back mix, including wrapping high address bits
    for (int i = 0; i < 16; i++) begin
      f3 = 3'($urandom_range(0, 4));
      do_store(f3, $urandom, $urandom);
    end

    // Reset during WAIT abandons the store
    poke(14'd5, 32'h1122_3344);
    if1.req_valid = 1'b1; if1.funct3 = 3'b000; if1.addr = 32'h16; if1.store_data = 32'hCD;
    @(posedge clk); #1;
    if1.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_state_wait", {62'd0, st1}, 64'd2);
    rst_n = 1'b0;
    #1;
    check("rst_mid_we", {63'd0, if1.mem_we}, 64'd0);
    check("rst_mid_ready", {63'd0, if1.req_ready}, 64'd1);
    check("rst_mid_wdata", {32'd0, if1.mem_wdata}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_ready_done", {62'd0, if1.req_ready, if1.done}, 64'd2);
    check("post_rst_ram", {32'd0, ram1[5]}, {32'd0, 32'h1122_3344});

    // RD_LAT=3 unit with req_valid held high
    poke(14'd5, 32'h1122_3344);
    if2.req_valid = 1'b1; if2.funct3 = 3'b000; if2.addr = 32'h16; if2.store_data = 32'hAB;
    exp2_q.push_back({14'd5, 32'h11AB_3344});
    check("lat3_ready_issue", {63'd0, if2.req_ready}, 64'd1);
    @(posedge clk);
    got_lat = 0; re_at = 0; we_at = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (if2.mem_re) re_at = n;
      if (if2.mem_we) we_at = n;
      if (if2.done) begin got_lat = n; break; end
      check("lat3_ready_busy", {63'd0, if2.req_ready}, 64'd0);
    end
    check("lat3_done_cycle", 64'(got_lat), 64'd6);
    check("lat3_re_cycle", 64'(re_at), 64'd1);
    check("lat3_we_cycle", 64'(we_at), 64'd5);
    check("lat3_ready_at_done", {63'd0, if2.req_ready}, 64'd1);
    // Still valid in the done cycle: accepted again at the next edge
    exp2_q.push_back({14'd5, 32'h11AB_3344});
    @(posedge clk); #1;
    if2.req_valid = 1'b0;
    got_lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (if2.done) begin got_lat = n; break; end
    end
    check("lat3_second_done", 64'(got_lat), 64'd6);
    check("ram2_final", {32'd0, ram2[5]}, {32'd0, 32'h11AB_3344});

    repeat (2) @(negedge clk);
    check("exp1_drained", 64'(exp1_q.size()), 64'd0);
    check("exp2_drained", 64'(exp2_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
- Write-side partner of the register-file load path: executes sb/sh/sw stores into word-organised data memory.
- Full-word stores are written directly.
- Byte and halfword stores use read-modify-write, merging the new lane into the existing word.
- Sits between the execute stage and the synchronous data RAM; stalls the core via `req_ready` while a store is in flight.

Parameters:
- ADDR_W, 14, word-address width of the data RAM (the RAM holds 2^ADDR_W words).
- RD_LAT, 1, RAM read latency in cycles, legal range 1..3. `mem_rdata` is valid RD_LAT cycles after the cycle in which `mem_re` is high.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  store request present.
- req_ready  out  1  unit idle; a request is accepted when `req_valid` and `req_ready` are both high at a rising edge.
- funct3  in  3  store width: 000 = sb, 001 = sh, 010 = sw; any other value is illegal.
- addr  in  32  byte address.
- store_data  in  32  rs2 value; the low byte or halfword is used for sb/sh.
- mem_addr  out  ADDR_W  word address, equal to `addr[ADDR_W+1:2]` latched at accept.
- mem_re  out  1  RAM read strobe.
- mem_we  out  1  RAM write strobe.
- mem_wdata  out  32  word to write.
- mem_rdata  in  32  RAM read data.
- done  out  1  one-cycle pulse: store committed.
- err  out  1  one-cycle pulse: request rejected (misaligned or illegal funct3); no memory access made.

Behaviour:
- Reset (asynchronous, while `reset`=0):
  - state = IDLE, so `req_ready`=1.
  - `mem_re`=0, `mem_we`=0, `done`=0, `err`=0.
  - `mem_addr`=0, `mem_wdata`=0, wait counter = 0.
  - Reset mid-operation abandons the store with no partial write; `mem_we` drops immediately, not at the next edge.
- States: IDLE, RD, WAIT, WR. `req_ready` = (state==IDLE). `mem_re` = (state==RD). `mem_we` = (state==WR). All are decoded from registered state.
- On accept, the unit latches addr, funct3 and store_data.
- Legality check at accept:
  - sh requires `addr[0]`=0.
  - sw requires `addr[1:0]`=00.
  - funct3 must be 000, 001 or 010.
  - If the check fails: state stays IDLE, `err`=1 in the next cycle only, no `mem_re` or `mem_we` ever asserted.
- sw path: IDLE → WR. `mem_wdata` = store_data. Then WR → IDLE with `done`=1 in the following cycle.
  - Accept at edge E0; write cycle is cycle 1; `done` is high in cycle 2.
- sb/sh path: IDLE → RD (1 cycle) → WAIT (RD_LAT cycles, counter counts down) → WR → IDLE with `done`=1.
  - `mem_rdata` is captured and merged on the last WAIT cycle.
  - With RD_LAT=1: RD in cycle 1, WAIT in cycle 2, WR in cycle 3, `done` in cycle 4.
- Merge rule (little-endian):
  - sb: lane = `addr[1:0]`; bits [8·lane+7 : 8·lane] = `store_data[7:0]`; all other bits come from `mem_rdata`.
  - sh: lane = `addr[1]`; bits [16·lane+15 : 16·lane] = `store_data[15:0]`; all other bits come from `mem_rdata`.
- `done` and `err` are registered pulses. `req_ready` is already 1 in the `done`/`err` cycle, so back-to-back requests are accepted with no bubble.
- While state != IDLE, `req_valid` is ignored. Changes to addr, store_data or funct3 after accept have no effect.
- `mem_addr` and `mem_wdata` hold their last values in IDLE.
- `mem_addr` is stable from RD through WR inclusive.
- Address bits above ADDR_W+1 are ignored, so addresses wrap modulo the RAM size.
- `done` and `err` are never high in the same cycle.

Test Plan:
- sb merge: RAM[5]=0x11223344; sb addr=0x16, data=0x000000AB, RD_LAT=1 → `mem_re` high in cycle 1, `mem_we` high in cycle 3 with `mem_wdata`=0x11AB3344, `done` in cycle 4, RAM[5]=0x11AB3344.
- sh upper lane: RAM[5]=0x11223344; sh addr=0x16, data=0x1234BEEF → `mem_wdata`=0xBEEF3344. Repeat with addr=0x14 → 0x1122BEEF.
- sw direct: sw addr=0x14, data=0xDEADBEEF → `mem_re` never asserted, `mem_we` in cycle 1, `done` in cycle 2. Then a second sb issued in the `done` cycle is accepted immediately.
- Misaligned and illegal: sw addr=0x15; sh addr=0x13; funct3=011 → each gives `err`=1 for exactly one cycle, `mem_we` and `mem_re` stay 0, `req_ready` stays 1.
- Reset mid-store: sb accepted; drive `reset`=0 during the WAIT cycle → `mem_we`=0 immediately, RAM[5] unchanged, after release `req_ready`=1 and `done`=0.
- Latency parameter: RD_LAT=3 sb → WAIT lasts 3 cycles, `done` in cycle 6. `req_valid` held high throughout is not re-accepted until the `done` cycle.
